// File: rtl/dmg_timer_pkg.sv
// dmg_timer_pkg: shared types and constants for the DMG timer unit.
//   tac_sel_t      : TAC[1:0] divider-tap select (named by the resulting TIMA rate in Hz)
//   ADDR_*         : register offsets inside the FF04-FF07 window
//   RELOAD_DELAY   : clocks from TIMA overflow to the TMA reload / irq
//   reload_state_t : reload FSM states
package dmg_timer_pkg;

  typedef enum logic [1:0] {
    SEL_4096   = 2'd0,  // div[9]
    SEL_262144 = 2'd1,  // div[3]
    SEL_65536  = 2'd2,  // div[5]
    SEL_16384  = 2'd3   // div[7]
  } tac_sel_t;

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  localparam int RELOAD_DELAY = 4;

  typedef enum logic {IDLE, RELOAD} reload_state_t;

endpackage

// File: rtl/dmg_timer_if.sv
// dmg_timer_if: register-window bus of the timer.
//   sel/addr/wr/din : CPU side write/select (master drives)
//   dout            : combinational read data (timer drives)
//   irq             : one-clk timer interrupt request (timer drives)
interface dmg_timer_if;
  logic       sel;
  logic [1:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (output sel, addr, wr, din, input dout, irq);
  modport slave  (input sel, addr, wr, din, output dout, irq);
endinterface

// File: rtl/dmg_timer_div.sv
// dmg_timer_div: free-running 16-bit divider plus the TIMA clock tap mux.
//   clk, nreset : system clock, async active-low reset (div <= DIV_RESET)
//   clr         : clear divider this clock (DIV write)
//   en, tsel    : timer enable / tap select, as they will be after this clock
//   div_hi      : div[15:8] (DIV read value)
//   tick_nxt    : en & tap, evaluated on the divider value after this clock
module dmg_timer_div
  import dmg_timer_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'h0000
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       clr,
  input  logic       en,
  input  tac_sel_t   tsel,
  output logic [7:0] div_hi,
  output logic       tick_nxt
);

  logic [15:0] div, div_nxt;
  logic        tap;

  assign div_nxt = clr ? 16'h0000 : div + 16'd1;

  // The tap is taken from the next divider value so the falling edge is
  // seen on the same posedge that makes it fall, including a DIV clear.
  always_comb begin
    tap = div_nxt[9];
    case (tsel)
      SEL_4096:   tap = div_nxt[9];
      SEL_262144: tap = div_nxt[3];
      SEL_65536:  tap = div_nxt[5];
      SEL_16384:  tap = div_nxt[7];
      default:    tap = div_nxt[9];
    endcase
  end

  assign tick_nxt = en & tap;
  assign div_hi   = div[15:8];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) div <= DIV_RESET;
    else         div <= div_nxt;
  end

endmodule

// File: rtl/dmg_timer.sv
// dmg_timer: DMG timer unit (DIV, TIMA, TMA, TAC) with timer interrupt.
//   clk    : 4.194304 MHz system clock
//   nreset : async active-low reset
//   bus    : dmg_timer_if.slave (sel/addr/wr/din in, dout/irq out)
// Build option: DMG_TIMER_RELOAD_DELAY_EN selects the 4-clk delayed TMA
// reload with cancel-on-TIMA-write; undefined reloads on the overflow edge.
module dmg_timer
  import dmg_timer_pkg::*;
#(
  parameter logic [15:0] DIV_RESET = 16'h0000
) (
  input  logic        clk,
  input  logic        nreset,
  dmg_timer_if.slave  bus
);

  logic [7:0] tima, tima_nxt, tma, tma_nxt, div_hi, rdata;
  logic [2:0] tac, tac_nxt;
  logic       tick_q, tick_nxt, fall, irq_q, irq_nxt;
  logic       wr_en, wr_div, wr_tima, wr_tma, wr_tac;

  assign wr_en   = bus.sel & bus.wr;
  assign wr_div  = wr_en & (bus.addr == ADDR_DIV);
  assign wr_tima = wr_en & (bus.addr == ADDR_TIMA);
  assign wr_tma  = wr_en & (bus.addr == ADDR_TMA);
  assign wr_tac  = wr_en & (bus.addr == ADDR_TAC);

  assign tac_nxt = wr_tac ? bus.din[2:0] : tac;
  assign tma_nxt = wr_tma ? bus.din : tma;

  dmg_timer_div #(.DIV_RESET(DIV_RESET)) u_div (
    .clk      (clk),
    .nreset   (nreset),
    .clr      (wr_div),
    .en       (tac_nxt[2]),
    .tsel     (tac_sel_t'(tac_nxt[1:0])),
    .div_hi   (div_hi),
    .tick_nxt (tick_nxt)
  );

  // tick is compared against its post-write value, so a DIV clear or a TAC
  // change that drops the tap counts as a falling edge.
  assign fall = tick_q & ~tick_nxt;

`ifdef DMG_TIMER_RELOAD_DELAY_EN
  reload_state_t state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tima_nxt  = tima;
    irq_nxt   = 1'b0;
    if (state == RELOAD && cnt == 3'd1) begin
      // Reload edge: TMA (including a same-cycle write) beats a TIMA write.
      tima_nxt  = tma_nxt;
      irq_nxt   = 1'b1;
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else if (wr_tima) begin
      // Write beats an increment edge and cancels a pending reload.
      tima_nxt  = bus.din;
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else begin
      if (state == RELOAD) cnt_nxt = cnt - 3'd1;
      if (fall) begin
        if (tima == 8'hFF) begin
          tima_nxt  = 8'h00;
          state_nxt = RELOAD;
          cnt_nxt   = 3'(RELOAD_DELAY);
        end else begin
          tima_nxt = tima + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
`else
  always_comb begin
    tima_nxt = tima;
    irq_nxt  = 1'b0;
    if (wr_tima) begin
      tima_nxt = bus.din;
    end else if (fall) begin
      if (tima == 8'hFF) begin
        tima_nxt = tma_nxt;
        irq_nxt  = 1'b1;
      end else begin
        tima_nxt = tima + 8'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima   <= 8'h00;
      tma    <= 8'h00;
      tac    <= 3'd0;
      tick_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      tima   <= tima_nxt;
      tma    <= tma_nxt;
      tac    <= tac_nxt;
      tick_q <= tick_nxt;
      irq_q  <= irq_nxt;
    end
  end

  always_comb begin
    rdata = 8'hFF;
    if (bus.sel) begin
      case (bus.addr)
        ADDR_DIV:  rdata = div_hi;
        ADDR_TIMA: rdata = tima;
        ADDR_TMA:  rdata = tma;
        ADDR_TAC:  rdata = {5'b11111, tac};
        default:   rdata = 8'hFF;
      endcase
    end
  end

  assign bus.dout = rdata;
  assign bus.irq  = irq_q;

endmodule

// File: tb/tb_dmg_timer.sv
// tb_dmg_timer: directed, table-driven bench for dmg_timer. Expected values
// follow whichever reload mode the build selects.
module tb_dmg_timer;
  import dmg_timer_pkg::*;

  logic clk = 1'b0;
  logic nreset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dmg_timer_if bus();

  dmg_timer #(.DIV_RESET(16'h0000)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Starts just after a negedge, ends on the following negedge.
  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.din = d;
    @(posedge clk);
    @(negedge clk);
    bus.wr = 1'b0; bus.sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
    bus.sel = 1'b1; bus.wr = 1'b0; bus.addr = a;
    #1;
    chk(name, bus.dout, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {7'd0, bus.irq}, {7'd0, exp});
  endtask

  // Leaves TIMA=FF one clock before the overflow edge N (div[3] tap).
  task automatic arm(input logic [7:0] t);
    wr_reg(ADDR_TAC, 8'h00);
    wr_reg(ADDR_TMA, t);
    wr_reg(ADDR_TIMA, 8'hFF);
    wr_reg(ADDR_DIV, 8'h00);
    wr_reg(ADDR_TAC, 8'h05);
    idle(14);
    chk_reg("arm_tima", ADDR_TIMA, 8'hFF);
  endtask

  logic [7:0] exp_t[6];
  logic       exp_i[6];

  initial begin
    bus.sel = 1'b0; bus.wr = 1'b0; bus.addr = 2'd0; bus.din = 8'h00;

`ifdef DMG_TIMER_RELOAD_DELAY_EN
    exp_t = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hAB};
    exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_t = '{8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAB};
    exp_i = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

    vecs[0] = '{ADDR_TMA,  8'hAB, 8'hAB};
    vecs[1] = '{ADDR_TAC,  8'hFA, 8'hFA};
    vecs[2] = '{ADDR_TAC,  8'h05, 8'hFD};
    vecs[3] = '{ADDR_TAC,  8'h00, 8'hF8};
    vecs[4] = '{ADDR_TIMA, 8'h5A, 8'h5A};
    vecs[5] = '{ADDR_TIMA, 8'hFF, 8'hFF};
    vecs[6] = '{ADDR_TMA,  8'h00, 8'h00};
    vecs[7] = '{ADDR_DIV,  8'h9C, 8'h00};

    // Reset state
    #2 nreset = 1'b0;
    idle(2);
    chk_reg("rst_div", ADDR_DIV, 8'h00);
    chk_reg("rst_tima", ADDR_TIMA, 8'h00);
    chk_reg("rst_tma", ADDR_TMA, 8'h00);
    chk_reg("rst_tac", ADDR_TAC, 8'hF8);
    chk_irq("rst_irq", 1'b0);
    idle(1);
    nreset = 1'b1;
    idle(1);

    // Register write/read-back table
    for (int i = 0; i < 8; i++) begin
      wr_reg(vecs[i].addr, vecs[i].din);
      chk_reg($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    bus.sel = 1'b0;
    #1 chk("unsel", bus.dout, 8'hFF);
    idle(1);

    // Prescaler div[3]: one TIMA step per 16 clocks
    wr_reg(ADDR_TAC, 8'h00);
    wr_reg(ADDR_TIMA, 8'h00);
    wr_reg(ADDR_DIV, 8'h00);
    wr_reg(ADDR_TAC, 8'h05);
    idle(14);
    chk_reg("pre_15", ADDR_TIMA, 8'h00);
    idle(1);
    chk_reg("pre_16", ADDR_TIMA, 8'h01);
    idle(16);
    chk_reg("pre_32", ADDR_TIMA, 8'h02);

    // Overflow and reload
    arm(8'hAB);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk_reg($sformatf("ovf_tima_n%0d", k), ADDR_TIMA, exp_t[k]);
      chk_irq($sformatf("ovf_irq_n%0d", k), exp_i[k]);
    end

    // TIMA write at N+2 cancels the reload
    arm(8'hAB);
    idle(2);
    wr_reg(ADDR_TIMA, 8'h42);
    for (int k = 0; k < 4; k++) begin
      chk_reg($sformatf("cancel_tima_%0d", k), ADDR_TIMA, 8'h42);
      chk_irq($sformatf("cancel_irq_%0d", k), 1'b0);
      idle(1);
    end

    // TMA write at N+4 is the reloaded value
    arm(8'hAB);
    idle(4);
    wr_reg(ADDR_TMA, 8'h77);
`ifdef DMG_TIMER_RELOAD_DELAY_EN
    chk_reg("tma_n4_tima", ADDR_TIMA, 8'h77);
    chk_irq("tma_n4_irq", 1'b1);
`else
    chk_reg("tma_n4_tima", ADDR_TIMA, 8'hAB);
    chk_irq("tma_n4_irq", 1'b0);
`endif
    idle(1);
    chk_irq("tma_n5_irq", 1'b0);

    // TIMA write at N+4 loses to the reload
    arm(8'hAB);
    idle(4);
    wr_reg(ADDR_TIMA, 8'h42);
`ifdef DMG_TIMER_RELOAD_DELAY_EN
    chk_reg("tima_n4_tima", ADDR_TIMA, 8'hAB);
    chk_irq("tima_n4_irq", 1'b1);
`else
    chk_reg("tima_n4_tima", ADDR_TIMA, 8'h42);
    chk_irq("tima_n4_irq", 1'b0);
`endif

    // DIV clear / timer disable while the tap is high
    wr_reg(ADDR_TAC, 8'h00);
    wr_reg(ADDR_TIMA, 8'h10);
    wr_reg(ADDR_DIV, 8'h00);
    wr_reg(ADDR_TAC, 8'h05);
    idle(7);
    wr_reg(ADDR_DIV, 8'h00);
    chk_reg("divclr_tima", ADDR_TIMA, 8'h11);
    chk_reg("divclr_div", ADDR_DIV, 8'h00);
    idle(8);
    wr_reg(ADDR_TAC, 8'h01);
    chk_reg("tacoff_tima", ADDR_TIMA, 8'h12);
    idle(20);
    chk_reg("tacoff_hold", ADDR_TIMA, 8'h12);

    // DIV read-out, clear at 1234 and full wrap
    wr_reg(ADDR_DIV, 8'h00);
    idle(16'h1234);
    chk_reg("div_1234", ADDR_DIV, 8'h12);
    wr_reg(ADDR_DIV, 8'h00);
    chk_reg("div_clr", ADDR_DIV, 8'h00);
    idle(255);
    chk_reg("div_00ff", ADDR_DIV, 8'h00);
    idle(1);
    chk_reg("div_0100", ADDR_DIV, 8'h01);
    idle(65279);
    chk_reg("div_ffff", ADDR_DIV, 8'hFF);
    idle(1);
    chk_reg("div_wrap", ADDR_DIV, 8'h00);

    // Reset asserted at N+2 of a reload
    arm(8'hAB);
    idle(3);
    nreset = 1'b0;
    chk_reg("mid_rst_tima", ADDR_TIMA, 8'h00);
    chk_reg("mid_rst_tma", ADDR_TMA, 8'h00);
    chk_reg("mid_rst_tac", ADDR_TAC, 8'hF8);
    chk_reg("mid_rst_div", ADDR_DIV, 8'h00);
    chk_irq("mid_rst_irq", 1'b0);
    idle(2);
    nreset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk_irq($sformatf("post_rst_irq_%0d", k), 1'b0);
      chk_reg($sformatf("post_rst_tima_%0d", k), ADDR_TIMA, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
